// File: rtl/base_vlat_sr_scan.sv
// base_vlat_sr_scan: round-robin drain stage for a vector of sticky
// set/reset status bits. Picks one pending, unmasked bit, presents its
// index over a valid/ready handshake, then pulses a one-hot clear back
// to the latch for one cycle.
//
// Ports:
//   clk     clock
//   reset   asynchronous, active-high reset
//   i_v     sticky status vector from the latch q (bit 0 = index 0)
//   i_mask  per-bit eligibility, 1 = may be reported
//   o_pend  combinational OR of (i_v & i_mask)
//   o_v     report valid, high exactly in PRESENT
//   o_r     report ready from the consumer
//   o_idx   index of the reported bit
//   o_clr   one-hot clear pulse to the latch rst input
module base_vlat_sr_scan #(
  parameter int unsigned width = 8,
  parameter int unsigned idx_w = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:width-1] i_v,
  input  logic [0:width-1] i_mask,
  output logic             o_pend,
  output logic             o_v,
  input  logic             o_r,
  output logic [0:idx_w-1] o_idx,
  output logic [0:width-1] o_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_e;

  localparam logic [idx_w-1:0] last_idx = idx_w'(width - 1);

  state_e           state_q, state_d;
  logic [idx_w-1:0] ptr_q, ptr_d;
  logic [idx_w-1:0] idx_q, idx_d;
  logic [0:width-1] clr_q, clr_d;
  logic             v_q, v_d;

  logic [0:width-1] cand;
  logic             sel_found;
  logic [idx_w-1:0] sel_idx;
  int unsigned      scan_pos;
  logic [idx_w-1:0] scan_idx;

  // Eligible pending bits; o_pend deliberately ignores masked bits.
  assign cand   = i_v & i_mask;
  assign o_pend = |cand;

  // Rotating-priority pick: first set bit at ptr, ptr+1, ..., wrapping
  // through width-1 back to 0. Positions are reduced modulo width, so an
  // index >= width can never be selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < width; k++) begin
      scan_pos = 32'(ptr_q) + k;
      if (scan_pos >= width) begin
        scan_pos = scan_pos - width;
      end
      scan_idx = idx_w'(scan_pos);
      if (!sel_found && cand[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    clr_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Report is held until accepted, even if the source bit drops.
        if (o_r) begin
          clr_d[idx_q] = 1'b1;
          ptr_d        = (idx_q == last_idx) ? '0 : idx_q + idx_w'(1);
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        // Latch clears on the closing edge; the next IDLE sees fresh i_v.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    v_d = (state_d == PRESENT);
  end

  // State register; reset aborts any clear pulse in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      v_q     <= v_d;
    end
  end

  assign o_v   = v_q;
  assign o_idx = idx_q;
  assign o_clr = clr_q;

endmodule

// File: tb/tb_base_vlat_sr_scan.sv
// Directed bench for base_vlat_sr_scan, driven from a small set-priority
// sticky latch model whose q feeds i_v and whose rst is o_clr.
module tb_base_vlat_sr_scan;

  localparam int unsigned width = 8;
  localparam int unsigned idx_w = 3;

  logic             clk;
  logic             reset;
  logic [0:width-1] i_mask;
  logic             o_pend;
  logic             o_v;
  logic             o_r;
  logic [0:idx_w-1] o_idx;
  logic [0:width-1] o_clr;

  logic [0:width-1] lat_q;
  logic [0:width-1] lat_set;
  logic             lat_init;

  int unsigned tests_run;
  int unsigned tests_failed;
  int unsigned cyc;

  base_vlat_sr_scan #(.width(width), .idx_w(idx_w)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_v    (lat_q),
    .i_mask (i_mask),
    .o_pend (o_pend),
    .o_v    (o_v),
    .o_r    (o_r),
    .o_idx  (o_idx),
    .o_clr  (o_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky latch: set wins over a coincident clear; not touched by reset.
  always @(posedge clk) begin
    if (lat_init) lat_q <= '0;
    else          lat_q <= (lat_q & ~o_clr) | lat_set;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle set pulse into the latch.
  task automatic pulse_set(input logic [0:width-1] v);
    lat_set = v;
    tick();
    lat_set = '0;
  endtask

  // Advance until o_v rises (bounded), check the index, return the cycle.
  task automatic expect_report(input string tag, input int exp_idx, output int unsigned at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_v) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'(o_v), 32'd1);
    else       check(tag, 32'(o_idx), 32'(exp_idx));
  endtask

  int unsigned c1, c2, c3;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    reset        = 1'b1;
    lat_init     = 1'b1;
    lat_set      = '0;
    i_mask       = '1;
    o_r          = 1'b1;
    tick(2);

    check("rst_v",    32'(o_v),    32'd0);
    check("rst_idx",  32'(o_idx),  32'd0);
    check("rst_clr",  32'(o_clr),  32'd0);
    check("rst_pend", 32'(o_pend), 32'd0);
    reset    = 1'b0;
    lat_init = 1'b0;
    tick();

    // 1. Single event on index 3.
    pulse_set(8'b0001_0000);
    check("t1_idle_v", 32'(o_v),    32'd0);
    check("t1_pend",   32'(o_pend), 32'd1);
    tick();
    check("t1_v",      32'(o_v),    32'd1);
    check("t1_idx",    32'(o_idx),  32'd3);
    check("t1_noclr",  32'(o_clr),  32'd0);
    tick();
    check("t1_clr_v",  32'(o_v),    32'd0);
    check("t1_clr",    32'(o_clr),  32'(8'b0001_0000));
    tick();
    check("t1_clr_end", 32'(o_clr), 32'd0);
    check("t1_iv",      32'(lat_q), 32'd0);
    tick();
    check("t1_quiet",   32'(o_v),   32'd0);
    // ptr is now 4: with bits 0 and 5 pending, 5 goes first.
    pulse_set(8'b1000_0100);
    expect_report("t1_ptr_a", 5, c1);
    expect_report("t1_ptr_b", 0, c2);
    check("t1_ptr_gap", c2 - c1, 32'd3);
    tick(2);

    // 2. Round robin with wrap from ptr=6.
    pulse_set(8'b0000_0100);
    expect_report("t2_pre", 5, c1);
    tick(2);
    pulse_set(8'b0100_0101);
    expect_report("t2_r0", 7, c1);
    expect_report("t2_r1", 1, c2);
    expect_report("t2_r2", 5, c3);
    check("t2_gap01", c2 - c1, 32'd3);
    check("t2_gap12", c3 - c2, 32'd3);
    tick(2);
    check("t2_empty", 32'(lat_q),  32'd0);
    check("t2_pend",  32'(o_pend), 32'd0);

    // 3. Backpressure on index 2.
    o_r = 1'b0;
    pulse_set(8'b0010_0000);
    expect_report("t3_rep", 2, c1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_v",   32'(o_v),   32'd1);
      check("t3_hold_idx", 32'(o_idx), 32'd2);
      check("t3_hold_clr", 32'(o_clr), 32'd0);
    end
    o_r = 1'b1;
    tick();
    check("t3_clr",   32'(o_clr), 32'(8'b0010_0000));
    check("t3_clr_v", 32'(o_v),   32'd0);
    tick();
    check("t3_clr_end", 32'(o_clr), 32'd0);
    check("t3_iv",      32'(lat_q), 32'd0);

    // 4. Masking: only index 6 eligible, index 7 stays pending.
    i_mask = 8'b0000_0010;
    pulse_set(8'b0000_0011);
    expect_report("t4_rep", 6, c1);
    tick();
    check("t4_clr", 32'(o_clr), 32'(8'b0000_0010));
    tick();
    check("t4_iv",   32'(lat_q),  32'(8'b0000_0001));
    check("t4_pend", 32'(o_pend), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_masked_v", 32'(o_v), 32'd0);
    end
    i_mask = '1;
    expect_report("t4_unmask", 7, c1);
    tick(2);
    check("t4_iv_end", 32'(lat_q), 32'd0);

    // 5. Set coincident with clear: set wins, bit re-reported.
    pulse_set(8'b0000_1000);
    expect_report("t5_rep1", 4, c1);
    tick();
    check("t5_clr", 32'(o_clr), 32'(8'b0000_1000));
    lat_set = 8'b0000_1000;
    tick();
    lat_set = '0;
    check("t5_kept", 32'(lat_q), 32'(8'b0000_1000));
    expect_report("t5_rep2", 4, c2);
    tick(2);
    check("t5_iv_end", 32'(lat_q), 32'd0);

    // 6a. Reset during PRESENT on index 5 (ptr was 5 before reset).
    o_r = 1'b0;
    pulse_set(8'b0000_0100);
    expect_report("t6_rep", 5, c1);
    reset = 1'b1;
    #1;
    check("t6_rst_v",   32'(o_v),   32'd0);
    check("t6_rst_idx", 32'(o_idx), 32'd0);
    check("t6_rst_clr", 32'(o_clr), 32'd0);
    #1;
    pulse_set(8'b0100_0000);
    reset = 1'b0;
    o_r   = 1'b1;
    check("t6_iv_held", 32'(lat_q), 32'(8'b0100_0100));
    // ptr reset to 0: index 1 precedes index 5.
    expect_report("t6_after_a", 1, c1);
    expect_report("t6_after_b", 5, c2);
    tick(2);

    // 6b. Reset during CLEAR aborts the pulse; bit stays set.
    pulse_set(8'b1000_0000);
    expect_report("t6_rep0", 0, c1);
    tick();
    check("t6_clr_live", 32'(o_clr), 32'(8'b1000_0000));
    reset = 1'b1;
    #1;
    check("t6_clr_abort", 32'(o_clr), 32'd0);
    tick();
    reset = 1'b0;
    check("t6_bit0_kept", 32'(lat_q), 32'(8'b1000_0000));
    expect_report("t6_rep0_again", 0, c1);
    tick(2);
    check("t6_iv_end", 32'(lat_q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/base_vlat_sr_scan.md
Name: base_vlat_sr_scan

Overview:
- Round-robin drain stage for a vector of sticky set/reset status bits held in a base_vlat_sr instance.
- Scans the latch's q vector and selects one pending, unmasked bit.
- Reports that bit's index to a consumer over a valid/ready handshake.
- After acceptance, returns a one-cycle, one-hot clear pulse that drives the latch's rst input.

Parameters:
- width, 8: number of status bits. Must match the upstream latch width.
- idx_w, 3: width of the reported index. Must satisfy 2**idx_w >= width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_v  input  [0:width-1]  sticky status vector, connected to latch q
- i_mask  input  [0:width-1]  per-bit enable; 1 = bit eligible for reporting
- o_pend  output  1  combinational OR of (i_v & i_mask)
- o_v  output  1  report valid
- o_r  input  1  report ready, from the consumer
- o_idx  output  [0:idx_w-1]  index of the reported bit; bit 0 = i_v[0]
- o_clr  output  [0:width-1]  one-hot clear pulse, connected to latch rst

Behaviour:
- State machine has three states: IDLE, PRESENT, CLEAR.
- Registered state: state, ptr [0:idx_w-1], o_idx, o_clr.
- Reset values: state=IDLE, ptr=0, o_v=0, o_idx=0, o_clr=0.
- o_v is 1 exactly when state==PRESENT.

IDLE:
- cand = i_v & i_mask.
- If cand is nonzero, select the first set bit found cyclically from ptr upward: ptr, ptr+1, ..., width-1, 0, ..., ptr-1.
- On the selecting edge, load o_idx with that index and go to PRESENT.
- If cand is zero, stay in IDLE.
- Latency: a bit visible on i_v in an IDLE cycle t produces o_v=1 in cycle t+1.

PRESENT:
- o_v=1. o_idx holds stable until the handshake.
- The report is never retracted, even if i_v or i_mask for that bit drops meanwhile.
- When o_v & o_r: register o_clr = one-hot(o_idx).
- Update ptr = o_idx+1, wrapping from width-1 to 0.
- Go to CLEAR.
- When o_r=0, hold all state.

CLEAR:
- o_clr is nonzero for exactly this one cycle; o_v=0.
- The latch clears on the closing edge of this cycle.
- Next state is IDLE, with o_clr=0.
- The IDLE cycle that follows sees the updated i_v, so the cleared bit is never double-reported.

Throughput: at most one report per 3 cycles (IDLE, PRESENT, CLEAR) when o_r is tied high.

Boundary conditions:
- Set coincident with clear: the latch gives set priority, so the bit remains 1 and is re-reported on a later scan. This is the required behaviour, not an error.
- All bits pending: reports are issued in strict cyclic order starting at ptr. No bit is starved.
- ptr=width-1 with only bit 0 pending: bit 0 is selected (wrap-around).
- Masked bits: never selected and never cleared; they remain pending in the latch. o_pend ignores them.
- Reset mid-PRESENT or mid-CLEAR: immediate return to reset values. Any o_clr pulse in flight is aborted, and the latch bit stays set.
- An index >= width is never produced. When width < 2**idx_w, the unused o_idx codes never occur.

Test Plan:
1. Single event: set i_v[3]=1 with mask all-ones and o_r=1 → o_v=1 with o_idx=3 one cycle later. Next cycle o_clr=0001_0000 for one cycle, then o_v stays 0. Final ptr=4.
2. Round robin with wrap: preload ptr=6 via prior reports, then set bits 1, 5 and 7 together → report order is 7, 1, 5, with spacing exactly 3 cycles each.
3. Backpressure: o_r=0 for 10 cycles while i_v[2]=1 → o_v=1 and o_idx=2 held constant, o_clr=0 throughout. Raise o_r → o_clr[2] pulses the cycle after.
4. Masking: i_v=0000_0011, i_mask=0000_0010 → only index 6 is reported, bit 7 stays pending, and o_pend=0 after the clear.
5. Set/clear collision: with the actual base_vlat_sr instance connected, re-assert set[4] in the CLEAR cycle → bit 4 stays 1 and is reported a second time.
6. Reset mid-operation: assert reset during PRESENT (o_idx=5) → o_v, o_clr, o_idx and ptr go to 0 asynchronously. After reset release, bit 5 (still set) is reported again.
